// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - shared FP32 format types and constants for the FP execute datapaths
package fp32_pkg;

   localparam int FP_EXP_W  = 8;
   localparam int FP_FRAC_W = 23;
   localparam int FP_BIAS   = 127;
   localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

   typedef struct packed {
      logic                 sign;
      logic [FP_EXP_W-1:0]  exp;
      logic [FP_FRAC_W-1:0] frac;
   } fp32_t;

   typedef enum logic [1:0] {
      FP_ZERO,
      FP_NORM,
      FP_INF,
      FP_NAN
   } fp_class_e;

   typedef enum logic [1:0] {
      IDLE,
      DIV,
      NORM,
      DONE
   } div_state_e;

endpackage

// File: rtl/fp32_classify.sv
// rtl/fp32_classify.sv - operand class decode; denormals are treated as zero
module fp32_classify
   import fp32_pkg::*;
(
   input  fp32_t     i_op,
   output fp_class_e o_class
);

   always_comb begin
      o_class = FP_NORM;
      if (i_op.exp == '0)
         o_class = FP_ZERO;
      else if (i_op.exp == '1)
         o_class = (i_op.frac == '0) ? FP_INF : FP_NAN;
   end

endmodule

// File: rtl/fp32_divide_seq.sv
// rtl/fp32_divide_seq.sv - sequential FP32 divider, restoring division one quotient bit per clock
module fp32_divide_seq
   import fp32_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] res,
   output logic        dz
);

   fp32_t      w_a;
   fp32_t      w_b;
   fp_class_e  w_ca;
   fp_class_e  w_cb;
   logic       w_sign;
   logic       w_special;
   logic [31:0] w_sp_res;
   logic       w_sp_dz;

   div_state_e r_state;
   logic        r_sign;
   logic [7:0]  r_ea;
   logic [7:0]  r_eb;
   logic [23:0] r_m2;
   logic [25:0] r_rem;
   logic [24:0] r_q;
   logic [4:0]  r_cnt;
   logic        r_busy;
   logic        r_done;
   logic [31:0] r_res;
   logic        r_dz;

   logic [25:0] w_trial;
   logic        w_qbit;
   logic [25:0] w_rem_sel;
   logic [9:0]  w_bias;
   logic signed [9:0] w_exp;
   logic [22:0] w_frac;

   assign w_a    = a;
   assign w_b    = b;
   assign w_sign = w_a.sign ^ w_b.sign;

   fp32_classify u_cls_a (.i_op(w_a), .o_class(w_ca));
   fp32_classify u_cls_b (.i_op(w_b), .o_class(w_cb));

   always_comb begin
      w_special = 1'b1;
      w_sp_res  = FP_QNAN;
      w_sp_dz   = 1'b0;
      if (w_ca == FP_NAN || w_cb == FP_NAN ||
          (w_ca == FP_ZERO && w_cb == FP_ZERO) || (w_ca == FP_INF && w_cb == FP_INF))
         w_sp_res = FP_QNAN;
      else if (w_ca == FP_INF)
         w_sp_res = {w_sign, 8'hFF, 23'h0};
      else if (w_cb == FP_INF)
         w_sp_res = {w_sign, 31'h0};
      else if (w_cb == FP_ZERO) begin
         w_sp_res = {w_sign, 8'hFF, 23'h0};
         w_sp_dz  = 1'b1;
      end
      else if (w_ca == FP_ZERO)
         w_sp_res = {w_sign, 31'h0};
      else
         w_special = 1'b0;
   end

   // Remainder stays below 2*m2 < 2^25, so bit 25 of the trial is its sign.
   assign w_trial   = r_rem - {2'b00, r_m2};
   assign w_qbit    = ~w_trial[25];
   assign w_rem_sel = w_qbit ? w_trial : r_rem;

   assign w_bias = r_q[24] ? 10'(FP_BIAS) : 10'(FP_BIAS - 1);
   assign w_exp  = $signed({2'b00, r_ea}) - $signed({2'b00, r_eb}) + $signed(w_bias);
   assign w_frac = r_q[24] ? r_q[23:1] : r_q[22:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_sign  <= 1'b0;
         r_ea    <= '0;
         r_eb    <= '0;
         r_m2    <= '0;
         r_rem   <= '0;
         r_q     <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_res   <= '0;
         r_dz    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_busy <= 1'b1;
                  r_sign <= w_sign;
                  r_ea   <= w_a.exp;
                  r_eb   <= w_b.exp;
                  r_m2   <= {1'b1, w_b.frac};
                  r_rem  <= {3'b001, w_a.frac};
                  r_q    <= '0;
                  r_cnt  <= 5'd24;
                  if (w_special) begin
                     r_res   <= w_sp_res;
                     r_dz    <= w_sp_dz;
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end else begin
                     r_state <= DIV;
                  end
               end
            end
            DIV: begin
               r_rem <= {w_rem_sel[24:0], 1'b0};
               r_q   <= {r_q[23:0], w_qbit};
               r_cnt <= r_cnt - 5'd1;
               if (r_cnt == 5'd0)
                  r_state <= NORM;
            end
            NORM: begin
               r_dz <= 1'b0;
               if (w_exp >= 10'sd255)
                  r_res <= {r_sign, 8'hFF, 23'h0};
               else if (w_exp <= 10'sd0)
                  r_res <= {r_sign, 31'h0};
               else
                  r_res <= {r_sign, w_exp[7:0], w_frac};
               r_done  <= 1'b1;
               r_state <= DONE;
            end
            DONE: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign res  = r_res;
   assign dz   = r_dz;

endmodule

// File: tb/tb_fp32_divide_seq.sv
// tb/tb_fp32_divide_seq.sv - scoreboard bench for fp32_divide_seq with directed vectors
module tb_fp32_divide_seq;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] a     = '0;
   logic [31:0] b     = '0;
   logic        busy;
   logic        done;
   logic [31:0] res;
   logic        dz;

   fp32_divide_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .res   (res),
      .dz    (dz)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic        dz;
      int          cyc;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic        dz;
      int          lat;
   } vec_t;

   exp_t sb[$];
   vec_t vt[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s act=%h req=%h", name, act, req);
      end
   endtask

   // Done is compared against the next queued expectation; lat is the cycle count of the done edge.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done act=%h req=none", res);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("res", res, e.res);
            chk("dz", {31'b0, dz}, {31'b0, e.dz});
            chk("latency", cyc, e.cyc);
         end
      end
   end

   task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] er, input logic ed, input int lat);
      @(negedge clk);
      a     = ia;
      b     = ib;
      start = 1'b1;
      sb.push_back(exp_t'{res: er, dz: ed, cyc: cyc + 1 + lat});
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         total++;
         bad++;
         $display("FAIL wait_idle_timeout act=%b req=0", busy);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog act=running req=finished");
      $fatal(1);
   end

   initial begin
      vt.push_back('{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 26});
      vt.push_back('{32'h3F800000, 32'h3FC00000, 32'h3F2AAAAA, 1'b0, 26});
      vt.push_back('{32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 26});
      vt.push_back('{32'h40E00000, 32'h40E00000, 32'h3F800000, 1'b0, 26});
      vt.push_back('{32'h40400000, 32'h3FC00000, 32'h40000000, 1'b0, 26});
      vt.push_back('{32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0, 26});
      vt.push_back('{32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 26});
      vt.push_back('{32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 0});
      vt.push_back('{32'h3F800000, 32'h80000000, 32'hFF800000, 1'b1, 0});
      vt.push_back('{32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 0});
      vt.push_back('{32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0, 0});
      vt.push_back('{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 0});
      vt.push_back('{32'h7F800000, 32'h40000000, 32'h7F800000, 1'b0, 0});
      vt.push_back('{32'h7F800000, 32'h00000000, 32'h7F800000, 1'b0, 0});
      vt.push_back('{32'h40000000, 32'hFF800000, 32'h80000000, 1'b0, 0});
      vt.push_back('{32'h80000000, 32'h40A00000, 32'h80000000, 1'b0, 0});
      vt.push_back('{32'h00000001, 32'h40000000, 32'h00000000, 1'b0, 0});

      repeat (3) @(negedge clk);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_res", res, 32'h0);
      chk("rst_dz", {31'b0, dz}, 32'd0);
      rst_n = 1'b1;

      issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 26);
      for (int i = 0; i < 25; i++) begin
         chk("busy_during_op", {31'b0, busy}, 32'd1);
         @(negedge clk);
      end
      wait_idle();

      foreach (vt[i]) begin
         issue(vt[i].a, vt[i].b, vt[i].r, vt[i].dz, vt[i].lat);
         wait_idle();
      end

      // Second start while busy must be ignored; start during done too.
      issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 26);
      repeat (4) @(negedge clk);
      a     = 32'h3F800000;
      b     = 32'h40400000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      begin
         int n = 0;
         while (!done && n < 60) begin
            @(negedge clk);
            n++;
         end
         if (!done) begin
            total++;
            bad++;
            $display("FAIL done_timeout act=%b req=1", done);
         end
      end
      a     = 32'h3F800000;
      b     = 32'h00000000;
      start = 1'b1;
      @(negedge clk);
      a = 32'h3F800000;
      b = 32'h40400000;
      sb.push_back(exp_t'{res: 32'h3EAAAAAA, dz: 1'b0, cyc: cyc + 1 + 26});
      @(negedge clk);
      start = 1'b0;
      wait_idle();

      // Abort with reset in the middle of DIV.
      a     = 32'h40C00000;
      b     = 32'h40000000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_done", {31'b0, done}, 32'd0);
      chk("abort_res", res, 32'h0);
      chk("abort_dz", {31'b0, dz}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 26);
      wait_idle();

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
